// File: rtl/weight_buffer_ctrl_pkg.sv
// weight_buffer_ctrl_pkg: FSM state encoding and sizing helper shared by the
// weight-buffer controller and its interface.  Rev 1.0
`default_nettype none

package weight_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Bits needed to index 'value' entries, never less than one.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_buffer_ctrl_if.sv
// weight_buffer_ctrl_if: fill stream, tap-load control and bank-side signals.
// Rev 1.0
`default_nettype none

interface weight_buffer_ctrl_if #(
  parameter int nb_pe_col    = 32,
  parameter int nb_taps      = 5,
  parameter int buffer_depth = 72,
  parameter int buffer_width = 16
);
  import weight_buffer_ctrl_pkg::*;

  localparam int buffer_addr_width = clogb2(buffer_depth);

  logic                                fill_start;
  logic [buffer_addr_width-1:0]        fill_base;
  logic [buffer_addr_width-1:0]        fill_rows;
  logic                                wr_valid;
  logic                                wr_ready;
  logic [buffer_width-1:0]             wr_data;
  logic                                load_start;
  logic [buffer_addr_width-1:0]        load_base;
  logic [3:0]                          n_ap;
  logic [buffer_addr_width-1:0]        wAddr;
  logic [buffer_addr_width-1:0]        rAddr;
  logic [nb_pe_col*buffer_width-1:0]   buffer_data_out;
  logic [nb_pe_col-1:0]                buffer_wEn;
  logic [nb_pe_col-1:0]                buffer_rEn;
  logic [nb_taps-1:0]                  weight_load_en;
  logic                                busy;
  logic                                fill_done;
  logic                                load_done;

  modport slave (
    input  fill_start, fill_base, fill_rows, wr_valid, wr_data,
           load_start, load_base, n_ap,
    output wr_ready, wAddr, rAddr, buffer_data_out, buffer_wEn, buffer_rEn,
           weight_load_en, busy, fill_done, load_done
  );

  modport master (
    output fill_start, fill_base, fill_rows, wr_valid, wr_data,
           load_start, load_base, n_ap,
    input  wr_ready, wAddr, rAddr, buffer_data_out, buffer_wEn, buffer_rEn,
           weight_load_en, busy, fill_done, load_done
  );

endinterface

`default_nettype wire

// File: rtl/weight_buffer_ctrl_addr_gen.sv
// weight_buffer_addr_gen: bank address counter with load and modulo-depth
// increment.  Rev 1.0
`default_nettype none

module weight_buffer_addr_gen #(
  parameter int depth  = 72,
  parameter int addr_w = 7
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load_i,
  input  wire logic [addr_w-1:0] load_val_i,
  input  wire logic              inc_i,
  output logic      [addr_w-1:0] addr_o
);

  logic [addr_w-1:0] addr_q;
  logic [addr_w-1:0] addr_d;

  // Wrap at depth-1 rather than at the natural 2^addr_w boundary.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = (addr_q == addr_w'(depth - 1)) ? '0 : addr_q + addr_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl: fills the weight banks column by column from a word
// stream and replays taps into the PE weight registers.  Rev 1.0
`default_nettype none

module weight_buffer_ctrl
  import weight_buffer_ctrl_pkg::*;
#(
  parameter int nb_pe_col         = 32,
  parameter int nb_taps           = 5,
  parameter int buffer_depth      = 72,
  parameter int buffer_width      = 16,
  parameter int buffer_addr_width = clogb2(buffer_depth),
  parameter int col_idx_width     = clogb2(nb_pe_col)
) (
  input wire logic              clk,
  input wire logic              rst,
  weight_buffer_ctrl_if.slave   bus
);

  state_e                         state_q, state_d;
  logic [col_idx_width-1:0]       col_q, col_d;
  logic [buffer_addr_width-1:0]   row_cnt_q, row_cnt_d;
  logic [buffer_addr_width-1:0]   rows_q, rows_d;
  logic [3:0]                     tap_q, tap_d;
  logic [3:0]                     n_q, n_d;
  logic                           fill_done_q, fill_done_d;
  logic                           load_zero_q, load_zero_d;

  logic                           wr_load, wr_inc, rd_load, rd_inc;
  logic                           xfer, last_col;
  logic [3:0]                     n_clamp;
  logic [nb_pe_col*buffer_width-1:0] data_rep;

  assign xfer     = (state_q == FILL) && bus.wr_valid;
  assign last_col = (col_q == col_idx_width'(nb_pe_col - 1));
  assign n_clamp  = (bus.n_ap > 4'(nb_taps)) ? 4'(nb_taps) : bus.n_ap;
  assign data_rep = {nb_pe_col{bus.wr_data}};

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_cnt_d   = row_cnt_q;
    rows_d      = rows_q;
    tap_d       = tap_q;
    n_d         = n_q;
    fill_done_d = 1'b0;
    load_zero_d = 1'b0;
    wr_load     = 1'b0;
    wr_inc      = 1'b0;
    rd_load     = 1'b0;
    rd_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          rows_d    = bus.fill_rows;
          col_d     = '0;
          row_cnt_d = '0;
          wr_load   = 1'b1;
          if (bus.fill_rows == '0) fill_done_d = 1'b1;
          else                     state_d     = FILL;
        end else if (bus.load_start) begin
          n_d     = n_clamp;
          tap_d   = '0;
          rd_load = 1'b1;
          if (n_clamp == 4'd0) load_zero_d = 1'b1;
          else                 state_d     = LOAD;
        end
      end
      FILL: begin
        if (xfer) begin
          col_d = last_col ? '0 : col_q + col_idx_width'(1);
          if (last_col) begin
            wr_inc    = 1'b1;
            row_cnt_d = row_cnt_q + buffer_addr_width'(1);
            if (row_cnt_q + buffer_addr_width'(1) == rows_q) begin
              fill_done_d = 1'b1;
              state_d     = IDLE;
            end
          end
        end
      end
      LOAD: begin
        rd_inc = 1'b1;
        tap_d  = tap_q + 4'd1;
        if (tap_q + 4'd1 == n_q) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_cnt_q   <= '0;
      rows_q      <= '0;
      tap_q       <= '0;
      n_q         <= '0;
      fill_done_q <= 1'b0;
      load_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_cnt_q   <= row_cnt_d;
      rows_q      <= rows_d;
      tap_q       <= tap_d;
      n_q         <= n_d;
      fill_done_q <= fill_done_d;
      load_zero_q <= load_zero_d;
    end
  end

  weight_buffer_addr_gen #(
    .depth  (buffer_depth),
    .addr_w (buffer_addr_width)
  ) u_wr_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wr_load),
    .load_val_i (bus.fill_base),
    .inc_i      (wr_inc),
    .addr_o     (bus.wAddr)
  );

  weight_buffer_addr_gen #(
    .depth  (buffer_depth),
    .addr_w (buffer_addr_width)
  ) u_rd_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rd_load),
    .load_val_i (bus.load_base),
    .inc_i      (rd_inc),
    .addr_o     (bus.rAddr)
  );

  // The bank returns tap t one cycle after its read, so the strobe trails
  // the tap counter by one; DRAIN carries the final strobe.
  assign bus.weight_load_en = (((state_q == LOAD) && (tap_q != 4'd0)) || (state_q == DRAIN))
                              ? (nb_taps'(1) << (tap_q - 4'd1)) : '0;

  assign bus.wr_ready        = (state_q == FILL);
  assign bus.buffer_wEn      = xfer ? (nb_pe_col'(1) << col_q) : '0;
  assign bus.buffer_data_out = xfer ? data_rep : '0;
  assign bus.buffer_rEn      = (state_q == LOAD) ? '1 : '0;
  assign bus.busy            = (state_q != IDLE);
  assign bus.fill_done       = fill_done_q;
  assign bus.load_done       = (state_q == DRAIN) || load_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_buffer_ctrl.sv
// tb_weight_buffer_ctrl: directed fill/load sequences against a cycle-stamped
// scoreboard of expected bank writes, reads, strobes and done pulses.
`default_nettype none

module tb_weight_buffer_ctrl;
  import weight_buffer_ctrl_pkg::*;

  localparam int NB_COL = 32;
  localparam int NB_TAPS = 5;
  localparam int DEPTH = 72;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int                        cyc;
    logic [31:0]               a;
    logic [31:0]               b;
    logic [NB_COL*WIDTH-1:0]   d;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t sq[$];
  int  fdq[$];
  int  ldq[$];

  weight_buffer_ctrl_if #(
    .nb_pe_col(NB_COL), .nb_taps(NB_TAPS), .buffer_depth(DEPTH), .buffer_width(WIDTH)
  ) bus ();

  weight_buffer_ctrl #(
    .nb_pe_col(NB_COL), .nb_taps(NB_TAPS), .buffer_depth(DEPTH), .buffer_width(WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: anything scheduled for this cycle must appear, nothing else may.
  always @(negedge clk) begin
    ev_t e;
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      e = wq.pop_front();
      chk("wr_wEn", bus.buffer_wEn, e.a);
      chk("wr_wAddr", bus.wAddr, e.b);
      chk("wr_data", bus.buffer_data_out, e.d);
    end else begin
      chk("idle_wEn", bus.buffer_wEn, 0);
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      e = rq.pop_front();
      chk("rd_rEn", bus.buffer_rEn, {NB_COL{1'b1}});
      chk("rd_rAddr", bus.rAddr, e.a);
    end else begin
      chk("idle_rEn", bus.buffer_rEn, 0);
    end
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      e = sq.pop_front();
      chk("strobe", bus.weight_load_en, e.a);
    end else begin
      chk("idle_strobe", bus.weight_load_en, 0);
    end
    if (fdq.size() > 0 && fdq[0] == cyc) begin
      void'(fdq.pop_front());
      chk("fill_done", bus.fill_done, 1);
    end else begin
      chk("fill_done_idle", bus.fill_done, 0);
    end
    if (ldq.size() > 0 && ldq[0] == cyc) begin
      void'(ldq.pop_front());
      chk("load_done", bus.load_done, 1);
    end else begin
      chk("load_done_idle", bus.load_done, 0);
    end
  end

  task automatic do_fill(input int base, input int rows, input bit toggle, input bit poke_load);
    int k;
    int col;
    int row;
    int ph;
    logic [WIDTH-1:0] w;
    logic [NB_COL-1:0] one;
    ev_t e;
    k = 0; col = 0; row = 0; ph = 0; one = 1;
    step();
    bus.fill_start = 1'b1;
    bus.load_start = poke_load;
    bus.fill_base = base[6:0];
    bus.fill_rows = rows[6:0];
    bus.load_base = 7'd3;
    bus.n_ap = 4'd2;
    if (rows == 0) fdq.push_back(cyc + 1);
    step();
    bus.fill_start = 1'b0;
    bus.load_start = 1'b0;
    if (rows != 0) begin
      while (k < rows * NB_COL) begin
        bus.load_start = poke_load && (k == 5);
        bus.wr_valid = toggle ? ph[0] : 1'b1;
        ph++;
        if (bus.wr_valid) begin
          w = WIDTH'($urandom);
          bus.wr_data = w;
          e.cyc = cyc;
          e.a = 32'(one << col);
          e.b = 32'((base + row) % DEPTH);
          e.d = {NB_COL{w}};
          wq.push_back(e);
          if (k == 5) begin
            #1;
            chk("fill_busy", bus.busy, 1);
            chk("fill_wr_ready", bus.wr_ready, 1);
          end
          k++;
          col++;
          if (col == NB_COL) begin
            col = 0;
            row++;
          end
        end
        step();
      end
      bus.wr_valid = 1'b0;
      bus.load_start = 1'b0;
      fdq.push_back(cyc);
      #1;
      chk("fill_end_busy", bus.busy, 0);
      chk("fill_end_wr_ready", bus.wr_ready, 0);
    end
    step();
  endtask

  // keep < n: reset lands at the edge closing the read of tap keep-1.
  task automatic do_load(input int base, input int nap, input int keep);
    int n;
    int c0;
    ev_t e;
    logic [NB_TAPS-1:0] one;
    one = 1;
    n = (nap > NB_TAPS) ? NB_TAPS : nap;
    step();
    bus.load_start = 1'b1;
    bus.load_base = base[6:0];
    bus.n_ap = nap[3:0];
    c0 = cyc;
    for (int t = 0; t < n; t++) begin
      if (t < keep) begin
        e.cyc = c0 + 1 + t; e.a = 32'((base + t) % DEPTH); e.b = 0; e.d = '0;
        rq.push_back(e);
      end
      if (t < keep - 1) begin
        e.cyc = c0 + 2 + t; e.a = 32'(one << t); e.b = 0; e.d = '0;
        sq.push_back(e);
      end
    end
    if (n == 0) ldq.push_back(c0 + 1);
    else if (keep >= n) ldq.push_back(c0 + 1 + n);
    step();
    bus.load_start = 1'b0;
    if (keep < n) begin
      repeat (keep - 1) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_rEn", bus.buffer_rEn, 0);
      chk("rst_strobe", bus.weight_load_en, 0);
      chk("rst_rAddr", bus.rAddr, 0);
      chk("rst_wAddr", bus.wAddr, 0);
      chk("rst_load_done", bus.load_done, 0);
    end else begin
      repeat (n + 1) step();
    end
  endtask

  initial begin
    bus.fill_start = 1'b0;
    bus.fill_base = '0;
    bus.fill_rows = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.load_start = 1'b0;
    bus.load_base = '0;
    bus.n_ap = '0;
    repeat (3) step();
    chk("reset_busy", bus.busy, 0);
    chk("reset_wr_ready", bus.wr_ready, 0);
    chk("reset_wAddr", bus.wAddr, 0);
    chk("reset_rAddr", bus.rAddr, 0);
    chk("reset_data", bus.buffer_data_out, 0);
    rst = 1'b0;
    step();

    do_fill(0, 2, 1'b0, 1'b1);
    do_fill(0, 2, 1'b1, 1'b0);
    do_fill(71, 2, 1'b0, 1'b0);
    do_fill(5, 0, 1'b0, 1'b0);

    do_load(70, 5, 99);
    do_load(3, 9, 99);
    do_load(10, 0, 99);
    do_load(70, 5, 3);
    do_load(70, 5, 99);

    repeat (3) step();
    chk("sb_left", wq.size() + rq.size() + sq.size() + fdq.size() + ldq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
